piso_buf_256b: RTL and testbench
================================

# piso_buf_256b

Parallel-in, serial-out buffer holding up to 64 32-bit words (256 B). A host writes words one per cycle into an internal memory, then issues `start`; the block drains every stored word as a serial bitstream, one bit per cycle, with a valid qualifier. This is the transmit-side counterpart of the team's serial-in, parallel-out capture buffer, used to push scan/test vectors back into the DUT chain.

## Interface
- `DEPTH`, 64: number of memory lines; must be a power of 2.
- `WIDTH`, 32: word width; also the number of bits shifted per word.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `pin`  in  32  parallel word to store.
- `pwr`  in  1  write strobe; stores `pin` at the write pointer.
- `start`  in  1  begin draining all stored words.
- `sout`  out  1  serial data.
- `sout_valid`  out  1  high in each cycle `sout` carries a payload bit.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE state.
- `done`  out  1  one-cycle pulse at the end of a drain.
- `wcount`  out  7  stored word count, 0..64.
- `full`  out  1  `wcount == 64`.

## Operation
- Reset values: `sout=0`, `sout_valid=0`, `busy=0`, `done=0`, `wcount=0`, `full=0`; FSM in IDLE; `wptr`, `rptr` and `bitcnt` are 0. Memory contents are don't-care.
- States: IDLE, READ, LOAD, SHIFT, DONE.
- IDLE:
  - `pwr` with `!full` writes `mem[wptr]`, then `wptr++` and `wcount++`.
  - `pwr` while full is dropped; no state changes.
  - `start` with `wcount>0` goes to READ.
  - `start` with `wcount==0` goes to DONE, with no bits shifted.
- Simultaneous `pwr` and `start` in IDLE: the write is performed first; the drain then includes that word.
- READ: asserts memory read enable at `rptr`. The memory read is synchronous with 1-cycle latency. Next state is LOAD.
- LOAD: the shift register captures the memory output; `bitcnt=0`. Next state is SHIFT.
- SHIFT:
  - `sout_valid=1`; `sout` is the shift register MSB (bit 31 first); the register shifts left by 1 each cycle.
  - When `bitcnt==31`: if `rptr==wcount-1`, go to DONE; otherwise `rptr++` and go to READ.
- DONE: `done=1` for one cycle; `wptr`, `rptr` and `wcount` are cleared; next state is IDLE.
- `pwr` and `start` are ignored in every state other than IDLE.
- `reset` in any state returns all registers to their reset values on the next edge and aborts any partial word. No further `sout_valid` follows.
- Width rules:
  - `wptr` and `rptr` are 6 bits; `wptr` wraps to 0 only through DONE or reset.
  - `wcount` is 7 bits so that 64 is representable.
  - `bitcnt` is 5 bits.

## Timing
- `start` sampled at edge t: `busy=1` from t+1 (READ). LOAD is at t+2. The first valid bit (bit 31 of word 0) is at t+3.
- Each word is 32 consecutive valid cycles, followed by a 2-cycle gap (READ, LOAD) with `sout_valid=0` before the next word.
- N words: the last valid bit is at cycle t+3+34(N-1)+31. `done` is high in the following cycle, and IDLE is reached the cycle after that.
- `wcount` and `full` update one cycle after an accepted `pwr`.
- `sout` is 0 whenever `sout_valid=0`.

## Configuration
- `PISO_BUF_LSB_FIRST_EN`:
  - Defined: bit order is LSB first. `sout` is bit 0 and the register shifts right.
  - Undefined (default): MSB first, as described above.
- Latency and framing are identical in both modes.

## Structure
- Package `piso_buf_pkg` holds:
  - the state enum (IDLE, READ, LOAD, SHIFT, DONE);
  - `PISO_DEPTH=64`, `PISO_WIDTH=32`;
  - derived widths `PTR_W=6`, `CNT_W=7`, `BIT_W=5`.
- Sub-module `piso_buf_ctrl` contains the FSM, pointers and counters, and drives the memory enables and shift/load strobes.
- The top level holds the memory instance (the library `mem_256B`) and the 32-bit shift register.

## Test plan
- Reset, write 1 word `0x8000_0001`, start → at t+3 `sout` is 1, then 30 zeros, then 1; `sout_valid` is high for exactly 32 cycles; `done` pulses; `wcount` returns to 0.
- Write `0xA5A5_A5A5`, `0x0000_FFFF`, `0x1234_5678`, then start → 96 valid bits match MSB-first concatenation, with a 2-cycle `sout_valid` gap between words.
- Write 64 words, then pulse `pwr` with `0xDEAD_BEEF` → `full=1`, `wcount` stays 64, and the drained stream contains no `0xDEAD_BEEF`.
- Start with `wcount=0` → `done` at t+1, `sout_valid` never asserted, `busy` high only in that DONE cycle.
- Assert reset at the 10th bit of word 1 of a 4-word drain → next cycle `sout_valid=0`, `busy=0`, `wcount=0`; a fresh 1-word write and drain works normally.
- With `PISO_BUF_LSB_FIRST_EN`, word `0x0000_0001` → first valid bit 1, followed by 31 zeros.

Source files
------------

// File: rtl/piso_buf_pkg.sv
// rtl/piso_buf_pkg.sv - shared types and sizes for the piso_buf_256b block
// Purpose: FSM state encoding, default geometry and derived counter widths.
package piso_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } piso_state_e;

  localparam int PISO_DEPTH = 64;
  localparam int PISO_WIDTH = 32;
  localparam int PTR_W      = 6;
  localparam int CNT_W      = 7;
  localparam int BIT_W      = 5;

endpackage

// File: rtl/mem_256B.sv
// rtl/mem_256B.sv - simple dual-port memory, synchronous read with 1-cycle latency
// Purpose: word storage for the parallel-in serial-out buffer.
// Ports: clk; we/waddr/wdata write port; re/raddr read port; rdata registered read data.
module mem_256B #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/piso_buf_ctrl.sv
// rtl/piso_buf_ctrl.sv - FSM, pointers and counters for the serial drain
// Purpose: accepts host writes in IDLE, then sequences READ/LOAD/SHIFT per word and
//          signals DONE after the last stored word has been shifted out.
// Ports: clk, reset (sync, active-high); pwr, start host controls;
//        mem_we/mem_waddr/mem_re/mem_raddr memory controls; load/shift shift-register strobes;
//        sout_valid, busy, done, wcount, full status.
module piso_buf_ctrl
  import piso_buf_pkg::*;
#(
  parameter int DEPTH = PISO_DEPTH,
  parameter int WIDTH = PISO_WIDTH,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1,
  parameter int BW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pwr,
  input  logic          start,
  output logic          mem_we,
  output logic [PW-1:0] mem_waddr,
  output logic          mem_re,
  output logic [PW-1:0] mem_raddr,
  output logic          load,
  output logic          shift,
  output logic          sout_valid,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] wcount,
  output logic          full
);

  localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
  localparam logic [2:0] S_READ  = 3'(ST_READ);
  localparam logic [2:0] S_LOAD  = 3'(ST_LOAD);
  localparam logic [2:0] S_SHIFT = 3'(ST_SHIFT);
  localparam logic [2:0] S_DONE  = 3'(ST_DONE);

  logic [2:0]    state, state_nxt;
  logic [PW-1:0] wptr, rptr;
  logic [BW-1:0] bitcnt;
  logic          wr_ok, last_bit, last_word;

  assign full      = (wcount == CW'(DEPTH));
  assign wr_ok     = (state == S_IDLE) && pwr && !full;
  assign last_bit  = (bitcnt == '1);
  // wcount >= 1 whenever SHIFT is active, so wcount-1 never underflows here
  assign last_word = ({1'b0, rptr} == (wcount - CW'(1)));

  assign mem_we     = wr_ok;
  assign mem_waddr  = wptr;
  assign mem_re     = (state == S_READ);
  assign mem_raddr  = rptr;
  assign load       = (state == S_LOAD);
  assign shift      = (state == S_SHIFT);
  assign sout_valid = shift;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      // a write accepted in the same cycle as start counts toward the drain
      S_IDLE:  if (start) state_nxt = (wr_ok || (wcount != '0)) ? S_READ : S_DONE;
      S_READ:  state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SHIFT;
      S_SHIFT: if (last_bit) state_nxt = last_word ? S_DONE : S_READ;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      wptr   <= '0;
      rptr   <= '0;
      bitcnt <= '0;
      wcount <= '0;
    end else begin
      state <= state_nxt;
      if (wr_ok) begin
        wptr   <= wptr + PW'(1);
        wcount <= wcount + CW'(1);
      end
      if (state == S_LOAD) begin
        bitcnt <= '0;
      end else if (state == S_SHIFT) begin
        bitcnt <= bitcnt + BW'(1);
      end
      if ((state == S_SHIFT) && last_bit && !last_word) begin
        rptr <= rptr + PW'(1);
      end
      if (state == S_DONE) begin
        wptr   <= '0;
        rptr   <= '0;
        wcount <= '0;
      end
    end
  end

endmodule

// File: rtl/piso_buf_256b.sv
// rtl/piso_buf_256b.sv - 64 x 32-bit parallel-in, serial-out transmit buffer
// Purpose: host writes words into memory, start drains them as a qualified bitstream.
// Ports: clk, reset (sync, active-high); pin/pwr parallel write; start drain request;
//        sout/sout_valid serial output; busy, done, wcount, full status.
// Config: PISO_BUF_LSB_FIRST_EN selects LSB-first bit order (default MSB-first).
module piso_buf_256b
  import piso_buf_pkg::*;
#(
  parameter int DEPTH = PISO_DEPTH,
  parameter int WIDTH = PISO_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         pin,
  input  logic                     pwr,
  input  logic                     start,
  output logic                     sout,
  output logic                     sout_valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   wcount,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);

  logic             mem_we, mem_re, load, shift;
  logic [PW-1:0]    mem_waddr, mem_raddr;
  logic [WIDTH-1:0] rdata, sreg;

  piso_buf_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .pwr        (pwr),
    .start      (start),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_re     (mem_re),
    .mem_raddr  (mem_raddr),
    .load       (load),
    .shift      (shift),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done),
    .wcount     (wcount),
    .full       (full)
  );

  mem_256B #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (pin),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= rdata;
    end else if (shift) begin
`ifdef PISO_BUF_LSB_FIRST_EN
      sreg <= sreg >> 1;
`else
      sreg <= sreg << 1;
`endif
    end
  end

  // gate with valid so sout is held at 0 between words and while idle
`ifdef PISO_BUF_LSB_FIRST_EN
  assign sout = sout_valid & sreg[0];
`else
  assign sout = sout_valid & sreg[WIDTH-1];
`endif

endmodule

// File: tb/tb_piso_buf_256b.sv
// tb/tb_piso_buf_256b.sv - self-checking bench for piso_buf_256b
module tb_piso_buf_256b;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pin;
  logic        pwr;
  logic        start;
  logic        sout, sout_valid, busy, done, full;
  logic [6:0]  wcount;

  int n_total = 0;
  int n_bad   = 0;

  logic        bits_q[$];
  logic [31:0] got_q[$];
  int          first_k, done_k, vcnt, pat_err, zero_err, busy_err;

  always #5 clk = ~clk;

  piso_buf_256b dut (
    .clk        (clk),
    .reset      (reset),
    .pin        (pin),
    .pwr        (pwr),
    .start      (start),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done),
    .wcount     (wcount),
    .full       (full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] w);
    pin = w;
    pwr = 1'b1;
    tick();
    pwr = 1'b0;
  endtask

  function automatic logic [31:0] mk(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, 16'h1200 ^ {8'h00, b}};
  endfunction

  // Issues start (optionally with a same-cycle write) and records the drain.
  // k counts cycles after the edge that sampled start; framing is checked per cycle.
  task automatic drain(input logic with_wr, input logic [31:0] wval, input int limit);
    logic exp_v;
    logic [31:0] word;
    bits_q.delete();
    got_q.delete();
    first_k = -1; done_k = -1; vcnt = 0; pat_err = 0; zero_err = 0; busy_err = 0;
    pin = wval;
    pwr = with_wr;
    start = 1'b1;
    tick();
    start = 1'b0;
    pwr = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      exp_v = (k >= 3) && (((k - 3) % 34) < 32);
      if (sout_valid !== exp_v) pat_err++;
      if (!busy) busy_err++;
      if (sout_valid) begin
        bits_q.push_back(sout);
        vcnt++;
        if (first_k < 0) first_k = k;
      end else if (sout !== 1'b0) begin
        zero_err++;
      end
      if (done) begin
        done_k = k;
        break;
      end
      tick();
    end
    if (done_k < 0) chk("drain_timeout", 32'(done_k), 32'(limit));
    for (int w = 0; w < bits_q.size() / 32; w++) begin
      word = '0;
      for (int b = 0; b < 32; b++) begin
`ifdef PISO_BUF_LSB_FIRST_EN
        word[b] = bits_q[w*32 + b];
`else
        word[31-b] = bits_q[w*32 + b];
`endif
      end
      got_q.push_back(word);
    end
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_wcount", 32'(wcount), 32'd0);
  endtask

  task automatic chk_framing(input string tag, input int nwords);
    chk({tag, "_first_k"}, 32'(first_k), (nwords == 0) ? 32'hFFFF_FFFF : 32'd3);
    chk({tag, "_done_k"}, 32'(done_k), (nwords == 0) ? 32'd1 : 32'(3 + 34*(nwords-1) + 32));
    chk({tag, "_vcnt"}, 32'(vcnt), 32'(32*nwords));
    chk({tag, "_pattern"}, 32'(pat_err), 32'd0);
    chk({tag, "_sout_zero"}, 32'(zero_err), 32'd0);
    chk({tag, "_busy"}, 32'(busy_err), 32'd0);
    chk({tag, "_nwords"}, 32'(got_q.size()), 32'(nwords));
  endtask

  initial begin
    int dead;
    reset = 1'b1; pin = '0; pwr = 1'b0; start = 1'b0;
    tick(); tick();
    chk("rst_sout", 32'(sout), 32'd0);
    chk("rst_valid", 32'(sout_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wcount", 32'(wcount), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    reset = 1'b0;
    tick();

    // single word with edge bits set
    write_word(32'h8000_0001);
    chk("w1_wcount", 32'(wcount), 32'd1);
    drain(1'b0, '0, 200);
    chk_framing("w1", 1);
    if (got_q.size() == 1) begin
      chk("w1_word", got_q[0], 32'h8000_0001);
      chk("w1_first_bit", 32'(bits_q[0]), 32'd1);
      chk("w1_last_bit", 32'(bits_q[31]), 32'd1);
    end

    // three words, 2-cycle gaps checked by the framing pattern
    write_word(32'hA5A5_A5A5);
    write_word(32'h0000_FFFF);
    write_word(32'h1234_5678);
    chk("w3_wcount", 32'(wcount), 32'd3);
    drain(1'b0, '0, 300);
    chk_framing("w3", 3);
    if (got_q.size() == 3) begin
      chk("w3_word0", got_q[0], 32'hA5A5_A5A5);
      chk("w3_word1", got_q[1], 32'h0000_FFFF);
      chk("w3_word2", got_q[2], 32'h1234_5678);
    end

    // fill to 64, overflow write must be dropped
    for (int i = 0; i < 64; i++) write_word(mk(i));
    chk("full_flag", 32'(full), 32'd1);
    chk("full_wcount", 32'(wcount), 32'd64);
    write_word(32'hDEAD_BEEF);
    chk("ovf_wcount", 32'(wcount), 32'd64);
    chk("ovf_full", 32'(full), 32'd1);
    drain(1'b0, '0, 3000);
    chk_framing("w64", 64);
    dead = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i] == 32'hDEAD_BEEF) dead++;
      chk($sformatf("w64_word%0d", i), got_q[i], mk(i));
    end
    chk("w64_no_deadbeef", 32'(dead), 32'd0);

    // empty start: straight to DONE
    drain(1'b0, '0, 20);
    chk_framing("empty", 0);

    // write and start in the same cycle from empty
    drain(1'b1, 32'h3C00_00C3, 200);
    chk_framing("simul", 1);
    if (got_q.size() == 1) chk("simul_word", got_q[0], 32'h3C00_00C3);

    // reset at the 10th bit of word 1 of a 4-word drain
    for (int i = 0; i < 4; i++) write_word(32'h0F0F_0000 + 32'(i));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (45) tick();
    chk("abort_pre_valid", 32'(sout_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_valid", 32'(sout_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wcount", 32'(wcount), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (3) begin
      tick();
      chk("abort_quiet", 32'(sout_valid), 32'd0);
    end
    write_word(32'h7654_3210);
    drain(1'b0, '0, 200);
    chk_framing("post", 1);
    if (got_q.size() == 1) chk("post_word", got_q[0], 32'h7654_3210);

`ifdef PISO_BUF_LSB_FIRST_EN
    write_word(32'h0000_0001);
    drain(1'b0, '0, 200);
    chk_framing("lsb", 1);
    if (bits_q.size() == 32) begin
      chk("lsb_first_bit", 32'(bits_q[0]), 32'd1);
      for (int b = 1; b < 32; b++) chk($sformatf("lsb_bit%0d", b), 32'(bits_q[b]), 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
